// File: rtl/singlecycle_pkg.sv
// -----------------------------------------------------------------------------
// singlecycle_pkg
// Shared definitions for the single-cycle ALU and its stimulus generator:
//   ALUSel_e      - ALU opcode encoding (ALU_ADD = 0 .. ALU_SLTU = 9)
//   ALU_NUM_OPS   - number of opcodes
//   ALU_CORNER_N  - number of entries in the operand corner table
//   CORNER        - operand corner-value table used by the directed sweep
//   LFSR_TAPS     - feedback mask of the right-shift Galois LFSR
//   lfsr_step()   - one LFSR step
// -----------------------------------------------------------------------------
package singlecycle_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_XOR  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_AND  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9
   } ALUSel_e;

   localparam int unsigned ALU_NUM_OPS  = 10;
   localparam int unsigned ALU_CORNER_N = 8;

   localparam logic [31:0] CORNER [ALU_CORNER_N] = '{
      32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000,
      32'h7FFF_FFFF, 32'h0000_001F, 32'h0000_0020, 32'hAAAA_AAAA
   };

   localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

   function automatic logic [31:0] lfsr_step(input logic [31:0] x);
      return (x >> 1) ^ (x[0] ? LFSR_TAPS : '0);
   endfunction

endpackage

// File: rtl/driver_alu_lfsr32.sv
// -----------------------------------------------------------------------------
// lfsr32
// 32-bit right-shift Galois LFSR with seed load and step enable.
//   i_clk    clock
//   i_rst    synchronous active-high reset, loads SEED
//   i_load   reload SEED (takes priority over i_step)
//   i_step   advance one step
//   o_state  current LFSR state
//   o_next   state after one more step (combinational look-ahead)
// -----------------------------------------------------------------------------
module lfsr32
   import singlecycle_pkg::*;
#(
   parameter logic [31:0] SEED = 32'h0000_0001
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_load,
   input  logic        i_step,
   output logic [31:0] o_state,
   output logic [31:0] o_next
);

   logic [31:0] r_state;
   logic [31:0] w_next;

   always_comb begin
      w_next = lfsr_step(r_state);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst || i_load) begin
         r_state <= SEED;
      end else if (i_step) begin
         r_state <= w_next;
      end
   end

   assign o_state = r_state;
   assign o_next  = w_next;

endmodule

// File: rtl/driver_alu.sv
// -----------------------------------------------------------------------------
// driver_alu
// Stimulus generator for the single-cycle ALU: a directed sweep of every
// opcode against the corner-value table for both operands, followed by
// NUM_RANDOM LFSR-based vectors. Vectors are offered with a valid/ready
// handshake; all outputs are registered.
//   i_clk         clock
//   i_rst         synchronous active-high reset
//   i_start       start pulse (honoured in IDLE or DONE only)
//   i_ready       consumer accepts the current vector when o_valid is high
//   o_operand_a   operand A of the current vector
//   o_operand_b   operand B of the current vector
//   o_alu_op      opcode of the current vector
//   o_valid       current vector valid
//   o_done        run complete, held until the next i_start
//   o_vector_cnt  accepted vectors in the current run
// -----------------------------------------------------------------------------
module driver_alu
   import singlecycle_pkg::*;
#(
   parameter int unsigned NUM_RANDOM = 1000,
   parameter logic [31:0] SEED_A     = 32'hACE1_2468,
   parameter logic [31:0] SEED_B     = 32'h1357_BDF9
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_start,
   input  logic        i_ready,
   output logic [31:0] o_operand_a,
   output logic [31:0] o_operand_b,
   output ALUSel_e     o_alu_op,
   output logic        o_valid,
   output logic        o_done,
   output logic [31:0] o_vector_cnt
);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_DIRECTED = 2'd1;
   localparam logic [1:0] S_RANDOM   = 2'd2;
   localparam logic [1:0] S_DONE     = 2'd3;

   localparam int unsigned DIR_LAST = ALU_NUM_OPS * ALU_CORNER_N * ALU_CORNER_N - 1;

   logic [1:0]  r_state;
   logic [9:0]  r_k;
   logic [31:0] r_rnd_cnt;
   logic [31:0] r_operand_a;
   logic [31:0] r_operand_b;
   ALUSel_e     r_alu_op;
   logic        r_valid;
   logic        r_done;
   logic [31:0] r_vector_cnt;

   logic        w_accept;
   logic        w_start;
   logic        w_step;
   logic [9:0]  w_k_next;
   logic [31:0] w_lfsr_a;
   logic [31:0] w_lfsr_b;
   logic [31:0] w_lfsr_a_next;
   logic [31:0] w_lfsr_b_next;

   always_comb begin
      w_accept = r_valid & i_ready;
      w_start  = i_start & ((r_state == S_IDLE) | (r_state == S_DONE));
      w_step   = w_accept & (r_state == S_RANDOM);
      w_k_next = r_k + 10'd1;
   end

   // The LFSR state always equals the random vector currently on display;
   // the look-ahead output provides the next vector for the registered outputs.
   lfsr32 #(.SEED(SEED_A)) u_lfsr_a (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_load  (w_start),
      .i_step  (w_step),
      .o_state (w_lfsr_a),
      .o_next  (w_lfsr_a_next)
   );

   lfsr32 #(.SEED(SEED_B)) u_lfsr_b (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_load  (w_start),
      .i_step  (w_step),
      .o_state (w_lfsr_b),
      .o_next  (w_lfsr_b_next)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= S_IDLE;
         r_k          <= '0;
         r_rnd_cnt    <= '0;
         r_operand_a  <= '0;
         r_operand_b  <= '0;
         r_alu_op     <= ALU_ADD;
         r_valid      <= 1'b0;
         r_done       <= 1'b0;
         r_vector_cnt <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (i_start) begin
                  r_state      <= S_DIRECTED;
                  r_k          <= '0;
                  r_rnd_cnt    <= '0;
                  r_operand_a  <= CORNER[0];
                  r_operand_b  <= CORNER[0];
                  r_alu_op     <= ALU_ADD;
                  r_valid      <= 1'b1;
                  r_done       <= 1'b0;
                  r_vector_cnt <= '0;
               end
            end

            S_DIRECTED: begin
               if (w_accept) begin
                  r_vector_cnt <= r_vector_cnt + 32'd1;
                  if (r_k == 10'(DIR_LAST)) begin
                     if (NUM_RANDOM == 0) begin
                        r_state <= S_DONE;
                        r_valid <= 1'b0;
                        r_done  <= 1'b1;
                     end else begin
                        r_state     <= S_RANDOM;
                        r_rnd_cnt   <= '0;
                        r_operand_a <= w_lfsr_a;
                        r_operand_b <= w_lfsr_b;
                        r_alu_op    <= ALU_ADD;
                     end
                  end else begin
                     // Index bits: [9:6] opcode, [5:3] operand A corner, [2:0] operand B corner.
                     r_k         <= w_k_next;
                     r_alu_op    <= ALUSel_e'(w_k_next[9:6]);
                     r_operand_a <= CORNER[w_k_next[5:3]];
                     r_operand_b <= CORNER[w_k_next[2:0]];
                  end
               end
            end

            S_RANDOM: begin
               if (w_accept) begin
                  r_vector_cnt <= r_vector_cnt + 32'd1;
                  if (r_rnd_cnt == 32'(NUM_RANDOM - 1)) begin
                     r_state <= S_DONE;
                     r_valid <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_rnd_cnt   <= r_rnd_cnt + 32'd1;
                     r_operand_a <= w_lfsr_a_next;
                     r_operand_b <= w_lfsr_b_next;
                     r_alu_op    <= (r_alu_op == ALU_SLTU) ? ALU_ADD
                                                           : ALUSel_e'(r_alu_op + 4'd1);
                  end
               end
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_operand_a  = r_operand_a;
   assign o_operand_b  = r_operand_b;
   assign o_alu_op     = r_alu_op;
   assign o_valid      = r_valid;
   assign o_done       = r_done;
   assign o_vector_cnt = r_vector_cnt;

endmodule

// File: tb/tb_driver_alu.sv
// -----------------------------------------------------------------------------
// tb_driver_alu
// Self-checking bench for driver_alu. Two instances share the inputs:
// u_dut with NUM_RANDOM=3 and u_dut0 with NUM_RANDOM=0.
// -----------------------------------------------------------------------------
module tb_driver_alu;
   import singlecycle_pkg::*;

   localparam logic [31:0] SA = 32'hACE1_2468;
   localparam logic [31:0] SB = 32'h1357_BDF9;
   localparam int          NVEC = 643;

   localparam logic [31:0] BC [8] = '{
      32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000,
      32'h7FFF_FFFF, 32'h0000_001F, 32'h0000_0020, 32'hAAAA_AAAA
   };

   logic        clk = 1'b0;
   logic        rst, start, ready;

   logic [31:0] a3, b3, c3, a0, b0, c0;
   ALUSel_e     op3, op0;
   logic        v3, d3, v0, d0;

   int checks = 0;
   int errors = 0;

   logic [31:0] cap_a  [0:699];
   logic [31:0] cap_b  [0:699];
   logic [3:0]  cap_op [0:699];
   logic [31:0] ref_a  [0:699];
   logic [31:0] ref_b  [0:699];
   logic [3:0]  ref_op [0:699];

   typedef struct {
      int          idx;
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
   } vec_t;

   vec_t tbl [12];

   always #5 clk = ~clk;

   driver_alu #(.NUM_RANDOM(3), .SEED_A(SA), .SEED_B(SB)) u_dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_ready(ready),
      .o_operand_a(a3), .o_operand_b(b3), .o_alu_op(op3),
      .o_valid(v3), .o_done(d3), .o_vector_cnt(c3)
   );

   driver_alu #(.NUM_RANDOM(0), .SEED_A(SA), .SEED_B(SB)) u_dut0 (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_ready(ready),
      .o_operand_a(a0), .o_operand_b(b0), .o_alu_op(op0),
      .o_valid(v0), .o_done(d0), .o_vector_cnt(c0)
   );

   initial begin
      #5_000_000;
      $display("FAIL watchdog time limit expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] tb_step(input logic [31:0] x);
      logic [31:0] y;
      y = {1'b0, x[31:1]};
      if (x[0]) y = y ^ 32'h8020_0003;
      return y;
   endfunction

   task automatic exp_vec(input int k, output logic [3:0] op,
                          output logic [31:0] a, output logic [31:0] b);
      logic [31:0] xa, xb;
      if (k < 640) begin
         op = 4'(k / 64);
         a  = BC[(k / 8) % 8];
         b  = BC[k % 8];
      end else begin
         xa = SA;
         xb = SB;
         for (int j = 640; j < k; j++) begin
            xa = tb_step(xa);
            xb = tb_step(xb);
         end
         op = 4'((k - 640) % 10);
         a  = xa;
         b  = xb;
      end
   endtask

   task automatic do_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Runs from the current negedge until u_dut reports done, recording every
   // accepted vector. Checks output stability across ready=0 cycles and the
   // NUM_RANDOM=0 instance's completion one cycle after vector 639.
   task automatic run_capture(input bit toggle, input bit mid_start, output int n);
      int          hold_err;
      bit          prev_hold;
      bit          saw639;
      logic [31:0] pa, pb;
      logic [3:0]  pop;
      n         = 0;
      hold_err  = 0;
      prev_hold = 1'b0;
      saw639    = 1'b0;
      pa = '0; pb = '0; pop = '0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         if (saw639) begin
            chk("nr0_done",  32'(d0), 32'd1);
            chk("nr0_valid", 32'(v0), 32'd0);
            chk("nr0_cnt",   c0,      32'd640);
            saw639 = 1'b0;
         end
         if (prev_hold && (a3 !== pa || b3 !== pb || op3 !== pop)) hold_err++;
         if (d3) break;
         ready = toggle ? ((cyc % 2) == 0) : 1'b1;
         start = (mid_start && n == 150) ? 1'b1 : 1'b0;
         if (v3 && ready && n < 700) begin
            cap_a[n]  = a3;
            cap_b[n]  = b3;
            cap_op[n] = op3;
            if (n == 639) saw639 = 1'b1;
            n++;
         end
         prev_hold = v3 && !ready;
         pa  = a3;
         pb  = b3;
         pop = op3;
         @(negedge clk);
      end
      start = 1'b0;
      chk("hold_stable", 32'(hold_err), 32'd0);
      chk("run_done", 32'(d3), 32'd1);
   endtask

   initial begin
      int          n1, n2, bad;
      logic [3:0]  eop;
      logic [31:0] ea, eb;

      tbl[0]  = '{0,   4'd0, 32'h0000_0000, 32'h0000_0000};
      tbl[1]  = '{9,   4'd0, 32'h0000_0001, 32'h0000_0001};
      tbl[2]  = '{26,  4'd0, 32'h8000_0000, 32'hFFFF_FFFF};
      tbl[3]  = '{77,  4'd1, 32'h0000_0001, 32'h0000_001F};
      tbl[4]  = '{100, 4'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
      tbl[5]  = '{200, 4'd3, 32'h0000_0001, 32'h0000_0000};
      tbl[6]  = '{300, 4'd4, 32'h0000_001F, 32'h7FFF_FFFF};
      tbl[7]  = '{511, 4'd7, 32'hAAAA_AAAA, 32'hAAAA_AAAA};
      tbl[8]  = '{639, 4'd9, 32'hAAAA_AAAA, 32'hAAAA_AAAA};
      tbl[9]  = '{640, 4'd0, 32'hACE1_2468, 32'h1357_BDF9};
      tbl[10] = '{641, 4'd1, 32'h5670_9234, 32'h898B_DEFF};
      tbl[11] = '{642, 4'd2, 32'h2B38_491A, 32'hC4E5_EF7C};

      rst   = 1'b1;
      start = 1'b0;
      ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_a",     a3,            32'd0);
      chk("rst_b",     b3,            32'd0);
      chk("rst_op",    {28'd0, op3},  32'd0);
      chk("rst_valid", 32'(v3),       32'd0);
      chk("rst_done",  32'(d3),       32'd0);
      chk("rst_cnt",   c3,            32'd0);
      chk("rst0_valid", 32'(v0),      32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_valid", 32'(v3), 32'd0);

      // Run 1: continuous ready
      do_start();
      chk("start_valid", 32'(v3),      32'd1);
      chk("start_cnt",   c3,           32'd0);
      chk("start_op",    {28'd0, op3}, 32'd0);
      chk("start_a",     a3,           32'd0);
      chk("start_b",     b3,           32'd0);
      run_capture(1'b0, 1'b0, n1);
      chk("run1_accepts", 32'(n1), 32'(NVEC));
      chk("run1_cnt",     c3,      32'd643);
      chk("run1_valid",   32'(v3), 32'd0);
      chk("run1_done",    32'(d3), 32'd1);

      foreach (tbl[i]) begin
         chk($sformatf("vec%0d_op", tbl[i].idx), {28'd0, cap_op[tbl[i].idx]}, {28'd0, tbl[i].op});
         chk($sformatf("vec%0d_a",  tbl[i].idx), cap_a[tbl[i].idx],           tbl[i].a);
         chk($sformatf("vec%0d_b",  tbl[i].idx), cap_b[tbl[i].idx],           tbl[i].b);
      end

      bad = 0;
      for (int k = 0; k < NVEC; k++) begin
         exp_vec(k, eop, ea, eb);
         if (cap_op[k] !== eop || cap_a[k] !== ea || cap_b[k] !== eb) bad++;
      end
      chk("stream_model_mismatches", 32'(bad), 32'd0);

      for (int k = 0; k < NVEC; k++) begin
         ref_a[k]  = cap_a[k];
         ref_b[k]  = cap_b[k];
         ref_op[k] = cap_op[k];
      end

      // Run 2: restart from DONE, ready toggling, start pulsed mid-sweep
      @(negedge clk);
      do_start();
      chk("rerun_start_valid", 32'(v3), 32'd1);
      chk("rerun_start_cnt",   c3,      32'd0);
      chk("rerun_start_done",  32'(d3), 32'd0);
      run_capture(1'b1, 1'b1, n2);
      chk("run2_accepts", 32'(n2), 32'(NVEC));
      chk("run2_cnt",     c3,      32'd643);
      bad = 0;
      for (int k = 0; k < NVEC; k++) begin
         if (cap_op[k] !== ref_op[k] || cap_a[k] !== ref_a[k] || cap_b[k] !== ref_b[k]) bad++;
      end
      chk("rerun_identical_mismatches", 32'(bad), 32'd0);

      // Run 3: reset while vector 300 is on display
      do_start();
      ready = 1'b1;
      for (int cyc = 0; cyc < 1000; cyc++) begin
         if (c3 == 32'd300) break;
         @(negedge clk);
      end
      chk("reach_k300",  c3,           32'd300);
      chk("k300_op",     {28'd0, op3}, 32'd4);
      chk("k300_a",      a3,           32'h0000_001F);
      chk("k300_b",      b3,           32'h7FFF_FFFF);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_a",     a3,           32'd0);
      chk("midrst_b",     b3,           32'd0);
      chk("midrst_op",    {28'd0, op3}, 32'd0);
      chk("midrst_valid", 32'(v3),      32'd0);
      chk("midrst_done",  32'(d3),      32'd0);
      chk("midrst_cnt",   c3,           32'd0);
      @(negedge clk);
      chk("midrst_idle_valid", 32'(v3), 32'd0);
      do_start();
      chk("restart_valid", 32'(v3),      32'd1);
      chk("restart_op",    {28'd0, op3}, 32'd0);
      chk("restart_a",     a3,           32'd0);
      chk("restart_b",     b3,           32'd0);
      chk("restart_cnt",   c3,           32'd0);
      repeat (9) @(negedge clk);
      chk("restart_k9_a",   a3, 32'h0000_0001);
      chk("restart_k9_b",   b3, 32'h0000_0001);
      chk("restart_k9_cnt", c3, 32'd9);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
